// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time instruction loader.
package loader_pkg;

  localparam int unsigned LDR_LEN_W  = 16;
  localparam int unsigned LDR_BYTE_W = 8;
  localparam int unsigned LDR_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    RUN,
    ERR
  } ldr_state_t;

  // States in which the loader is listening on the byte stream.
  function automatic logic ldr_rx_open(ldr_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/inst_loader.sv
// Length-prefixed, XOR-checksummed byte stream to 32-bit instruction memory writes;
// holds the processor in reset until a verified image is in place.
module inst_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [LDR_BYTE_W-1:0] rx_data,
  output logic                  rx_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [LDR_WORD_W-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_err
);

  ldr_state_t state_q, state_d;

  logic [LDR_LEN_W-1:0]  len_q, len_d;
  logic [LDR_LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [LDR_WORD_W-1:0] shift_q, shift_d;
  logic [LDR_BYTE_W-1:0] xor_q, xor_d;

  logic                  rx_ready_q, rx_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]     imem_addr_q, imem_addr_d;
  logic [LDR_WORD_W-1:0] imem_wdata_q, imem_wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;

  logic                  accept_c;
  logic [LDR_LEN_W-1:0]  len_rx_c;
  logic                  word_last_c;

  assign accept_c    = rx_valid && rx_ready_q;
  assign len_rx_c    = {rx_data, len_q[LDR_BYTE_W-1:0]};
  assign word_last_c = (byte_cnt_q == 2'd3) &&
                       (LDR_LEN_W'(word_cnt_q + LDR_LEN_W'(1)) == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = LEN_LO;
      LEN_LO: if (accept_c) state_d = LEN_HI;
      LEN_HI: begin
        if (accept_c) begin
          if (len_rx_c == '0)                     state_d = CSUM;
          else if (32'(len_rx_c) > IMEM_DEPTH)    state_d = ERR;
          else                                    state_d = DATA;
        end
      end
      DATA:   if (accept_c && word_last_c) state_d = CSUM;
      CSUM:   if (accept_c) state_d = (rx_data == xor_q) ? RUN : ERR;
      RUN,
      ERR:    if (reload) state_d = LEN_LO;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    xor_d        = xor_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    unique case (state_q)
      LEN_LO: if (accept_c) len_d = LDR_LEN_W'(rx_data);
      LEN_HI: if (accept_c) len_d = len_rx_c;
      DATA: begin
        if (accept_c) begin
          // Little-endian packing: each new byte enters at the top and shifts down.
          shift_d    = {rx_data, shift_q[LDR_WORD_W-1:LDR_BYTE_W]};
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ADDR_W'(word_cnt_q);
            imem_wdata_d = {rx_data, shift_q[LDR_WORD_W-1:LDR_BYTE_W]};
            word_cnt_d   = LDR_LEN_W'(word_cnt_q + LDR_LEN_W'(1));
          end
        end
      end
      RUN,
      ERR: begin
        if (reload) begin
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          xor_d      = '0;
        end
      end
      default: ;
    endcase

    rx_ready_d  = ldr_rx_open(state_d);
    cpu_rst_d   = (state_d != RUN);
    load_done_d = (state_d == RUN);
    load_err_d  = (state_d == ERR);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      xor_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      xor_q        <= xor_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
